load_store_unit: RTL and testbench

Sits between the core's execute stage and the byte-addressed `ram` data memory, directly upstream of it. It accepts one load/store request at a time over a valid/ready handshake and checks alignment, range and funct3. It drives the RAM's one-hot `write_enable` (bit0 word, bit1 half, bit2 byte), then returns sign- or zero-extended load data, or a fault, over a second valid/ready handshake.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-addressed big-endian RAM.
// Validates each request, issues one RAM access cycle, and returns extended load data or a fault.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [2:0]  mem_write_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        illegal_funct3;
    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;
    logic [31:0] load_value;

    // Fault classification of the incoming request; the end address is
    // computed in 33 bits so that an access wrapping past 2^32 also faults.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd4;
        endcase
    end

    assign illegal_funct3 = req_write ? (req_funct3 > 3'b010)
                                      : (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    assign misaligned     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_end        = {1'b0, req_addr} + {30'b0, req_size};
    assign out_of_range   = req_end > 33'(MEM_BYTES);
    assign req_fault      = illegal_funct3 || misaligned || out_of_range;

    // RAM returns bytes big-endian, so the addressed byte/half sits in the top bits.
    always_comb begin
        case (funct3_q)
            3'b000:  load_value = {{24{mem_data_out[31]}}, mem_data_out[31:24]};
            3'b001:  load_value = {{16{mem_data_out[31]}}, mem_data_out[31:16]};
            3'b010:  load_value = mem_data_out;
            3'b100:  load_value = {24'b0, mem_data_out[31:24]};
            3'b101:  load_value = {16'b0, mem_data_out[31:16]};
            default: load_value = 32'b0;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 3'b000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
                // Gating by reset keeps an aborted store from committing at the reset edge.
                if (write_q && !reset) begin
                    case (funct3_q[1:0])
                        2'b00:   mem_write_enable = 3'b100;
                        2'b01:   mem_write_enable = 3'b010;
                        2'b10:   mem_write_enable = 3'b001;
                        default: mem_write_enable = 3'b000;
                    endcase
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            rdata_q  <= 32'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        fault_q  <= req_fault;
                        rdata_q  <= 32'b0;
                    end
                end
                ACCESS: begin
                    rdata_q <= write_q ? 32'b0 : load_value;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign resp_rdata  = rdata_q;
    assign resp_fault  = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM, transaction-level reference model,
// per-cycle compare process and directed requests with literal expectations.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [2:0]  mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Attached RAM: big-endian, combinational read, one-hot write enable.
    logic [7:0]  ram [0:MEM_BYTES-1];
    logic [11:0] ra;
    assign ra = mem_addr[11:0];
    assign mem_data_out = {ram[ra], ram[ra + 12'd1], ram[ra + 12'd2], ram[ra + 12'd3]};

    always @(posedge clk) begin
        case (mem_write_enable)
            3'b001: begin
                ram[ra]         <= mem_data_in[31:24];
                ram[ra + 12'd1] <= mem_data_in[23:16];
                ram[ra + 12'd2] <= mem_data_in[15:8];
                ram[ra + 12'd3] <= mem_data_in[7:0];
            end
            3'b010: begin
                ram[ra]         <= mem_data_in[15:8];
                ram[ra + 12'd1] <= mem_data_in[7:0];
            end
            3'b100: ram[ra] <= mem_data_in[7:0];
            default: ;
        endcase
    end

    // Reference model: its own memory image plus the outstanding transaction.
    logic [7:0]  m_mem [0:MEM_BYTES-1];
    logic        m_started = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_wait = 1'b0;
    logic        m_post_reset = 1'b0;
    logic        m_write = 1'b0;
    logic [2:0]  m_f3 = 3'b000;
    logic [31:0] m_addr = 32'b0;
    logic [31:0] m_wdata = 32'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_rdata = 32'b0;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            ram[i]   = 8'h00;
            m_mem[i] = 8'h00;
        end
    end

    function automatic logic model_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
        longint size;
        logic   bad;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (w) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else   bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (size == 2 && a[0]) bad = 1'b1;
        if (size == 4 && a[1:0] != 2'b00) bad = 1'b1;
        if (longint'(a) + size > longint'(MEM_BYTES)) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int b0, b1, b2, b3;
        b0 = m_mem[a[11:0]];
        b1 = m_mem[a[11:0] + 12'd1];
        b2 = m_mem[a[11:0] + 12'd2];
        b3 = m_mem[a[11:0] + 12'd3];
        case (f3)
            3'd0: return 32'(b0 >= 128 ? b0 - 256 : b0);
            3'd1: return 32'((b0 * 256 + b1) >= 32768 ? (b0 * 256 + b1) - 65536 : (b0 * 256 + b1));
            3'd2: return 32'(b0 * 16777216 + b1 * 65536 + b2 * 256 + b3);
            3'd4: return 32'(b0);
            3'd5: return 32'(b0 * 256 + b1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] expected_we(input logic busy, input logic wt, input logic w,
                                               input logic [2:0] f3, input logic rst);
        if (!(busy && wt && w) || rst) return 3'b000;
        case (f3)
            3'd0: return 3'b100;
            3'd1: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_started    <= 1'b1;
            m_busy       <= 1'b0;
            m_wait       <= 1'b0;
            m_post_reset <= 1'b1;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy       <= 1'b1;
                m_post_reset <= 1'b0;
                m_write      <= req_write;
                m_f3         <= req_funct3;
                m_addr       <= req_addr;
                m_wdata      <= req_wdata;
                m_fault      <= model_fault(req_write, req_funct3, req_addr);
                m_wait       <= !model_fault(req_write, req_funct3, req_addr);
                m_rdata      <= (req_write || model_fault(req_write, req_funct3, req_addr))
                                ? 32'd0 : model_load(req_funct3, req_addr);
            end
        end else if (m_wait) begin
            m_wait <= 1'b0;
            if (m_write) begin
                case (m_f3)
                    3'd0: m_mem[m_addr[11:0]] <= m_wdata[7:0];
                    3'd1: begin
                        m_mem[m_addr[11:0]]         <= m_wdata[15:8];
                        m_mem[m_addr[11:0] + 12'd1] <= m_wdata[7:0];
                    end
                    default: begin
                        m_mem[m_addr[11:0]]         <= m_wdata[31:24];
                        m_mem[m_addr[11:0] + 12'd1] <= m_wdata[23:16];
                        m_mem[m_addr[11:0] + 12'd2] <= m_wdata[15:8];
                        m_mem[m_addr[11:0] + 12'd3] <= m_wdata[7:0];
                    end
                endcase
            end
        end else if (resp_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
            check("resp_valid", {31'b0, resp_valid}, {31'b0, m_busy && !m_wait});
            check("mem_write_enable", {29'b0, mem_write_enable},
                  {29'b0, expected_we(m_busy, m_wait, m_write, m_f3, reset)});
            if (m_busy && !m_wait) begin
                check("resp_rdata", resp_rdata, m_rdata);
                check("resp_fault", {31'b0, resp_fault}, {31'b0, m_fault});
            end
            if (m_busy && m_wait) begin
                check("mem_addr", mem_addr, m_addr);
                if (m_write) check("mem_data_in", mem_data_in, m_wdata);
            end
            if (m_post_reset) begin
                check("reset_rdata", resp_rdata, 32'd0);
                check("reset_fault", {31'b0, resp_fault}, 32'd0);
                check("reset_mem_addr", mem_addr, 32'd0);
                check("reset_mem_data_in", mem_data_in, 32'd0);
            end
        end
    end

    // One request/response; exp_wait is the number of sampled cycles between
    // acceptance and the first resp_valid (1 through ACCESS, 0 for a fault).
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int exp_wait, input int hold);
        int waits;
        bit seen;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waits = 0;
        seen  = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            else waits++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no resp_valid for addr %h, required within 8 cycles", a);
            return;
        end
        check("lit_rdata", resp_rdata, exp_rdata);
        check("lit_fault", {31'b0, resp_fault}, {31'b0, exp_fault});
        check("lit_latency", waits, exp_wait);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_funct3 = 3'b000;
            req_addr   = 32'h30;
            req_wdata  = 32'h55;
            @(negedge clk);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1, 0);

        do_req(1'b1, 3'd0, 32'h5, 32'h000000AB, 32'h0,        1'b0, 1, 0);
        do_req(1'b1, 3'd1, 32'h6, 32'h00008001, 32'h0,        1'b0, 1, 0);
        do_req(1'b0, 3'd0, 32'h5, 32'h0,        32'hFFFFFFAB, 1'b0, 1, 0);
        do_req(1'b0, 3'd4, 32'h5, 32'h0,        32'h000000AB, 1'b0, 1, 0);
        do_req(1'b0, 3'd1, 32'h6, 32'h0,        32'hFFFF8001, 1'b0, 1, 0);
        do_req(1'b0, 3'd5, 32'h6, 32'h0,        32'h00008001, 1'b0, 1, 0);
        do_req(1'b0, 3'd2, 32'h4, 32'h0,        32'h00AB8001, 1'b0, 1, 0);

        do_req(1'b0, 3'd2, 32'h2,        32'h0,        32'h0, 1'b1, 0, 0);
        do_req(1'b1, 3'd1, 32'h3,        32'h0000BEEF, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'd2, 32'hFFC,      32'h0,        32'h0, 1'b0, 1, 0);
        do_req(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,        32'h0, 1'b1, 0, 0);
        do_req(1'b1, 3'd4, 32'h40,       32'h11223344, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, 3'd3, 32'h40,       32'h0,        32'h0, 1'b1, 0, 0);

        do_req(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, 3);
        do_req(1'b0, 3'd0, 32'h30, 32'h0, 32'h00000000, 1'b0, 1, 0);

        // Abort a store while it is in its memory cycle.
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        check("rst_write_enable", {29'b0, mem_write_enable}, 32'd0);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 32'h00000000, 1'b0, 1, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
